// File: rtl/dm_pkg.sv
// Shared types and helpers for the banked data memory.
package dm_pkg;

   localparam int unsigned BYTE_LANES = 4;
   localparam int unsigned WORD_W     = 32;

   typedef enum logic [1:0] {
      CLEAR = 2'd0,
      IDLE  = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   typedef struct packed {
      logic [WORD_W-1:0] addr;
      logic [WORD_W-1:0] wdata;
   } trace_t;

   // Lane i takes the new byte where its enable is set, else keeps the old byte.
   function automatic logic [WORD_W-1:0] merge_bytes(
      input logic [WORD_W-1:0]     old,
      input logic [WORD_W-1:0]     wdata,
      input logic [BYTE_LANES-1:0] byteen
   );
      logic [WORD_W-1:0] merged;
      merged = old;
      for (int i = 0; i < int'(BYTE_LANES); i++) begin
         if (byteen[i]) merged[i*8 +: 8] = wdata[i*8 +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/dm_banked_mem_array.sv
// DEPTH x 32 word storage: one synchronous write port, one asynchronous read port.
module dm_word_array
   import dm_pkg::*;
#(
   parameter int unsigned DEPTH = 4096,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [WORD_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [WORD_W-1:0] rdata_c
);

   logic [WORD_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata_c = mem[raddr];

endmodule

// File: rtl/dm_banked_mem.sv
// Data memory with req/ready handshake, configurable read latency,
// out-of-range error reporting, post-reset clear sweep and a write-trace port.
module dm_banked_mem
   import dm_pkg::*;
#(
   parameter int unsigned DEPTH          = 4096,
   parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
   parameter int unsigned LATENCY        = 0,
   parameter bit          CLEAR_ON_RESET = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req,
   input  logic [BYTE_LANES-1:0] byteen,
   input  logic [WORD_W-1:0]     addr,
   input  logic [WORD_W-1:0]     wdata,
   output logic                  ready,
   output logic                  busy,
   output logic                  resp_valid,
   output logic [WORD_W-1:0]     rdata,
   output logic                  err,
   output logic                  trace_valid,
   output logic [WORD_W-1:0]     trace_addr,
   output logic [WORD_W-1:0]     trace_wdata
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = 3;
   localparam state_t      RST_STATE = CLEAR_ON_RESET ? CLEAR : IDLE;

   state_t            state, state_next;
   logic [AW-1:0]     clr_cnt, clr_cnt_next;
   logic [CW-1:0]     wait_cnt, wait_cnt_next;

   logic [29:0]       idx;
   logic              in_range;
   logic              is_write;
   logic              accept;

   logic [WORD_W-1:0] mem_rdata_c;
   logic [WORD_W-1:0] merged_c;
   logic              we_c;
   logic [AW-1:0]     waddr_c;
   logic [WORD_W-1:0] wdata_c;

   logic              ready_next;
   logic              busy_next;
   logic              resp_valid_next;
   logic              err_next;
   logic              trace_valid_next;
   logic [WORD_W-1:0] rdata_next;
   trace_t            trace_q, trace_next;

   // Address decode: wrap-around offset from the base, word index, range check.
   always_comb begin : decode
      idx      = 30'((addr - BASE_ADDR) >> 2);
      in_range = (32'(idx) < DEPTH);
      is_write = (byteen != '0);
      accept   = req && ready;
   end

   assign merged_c = merge_bytes(mem_rdata_c, wdata, byteen);

   dm_word_array #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_array (
      .clk     (clk),
      .we      (we_c),
      .waddr   (waddr_c),
      .wdata   (wdata_c),
      .raddr   (idx[AW-1:0]),
      .rdata_c (mem_rdata_c)
   );

   always_ff @(posedge clk or negedge reset) begin : state_reg
      if (!reset) begin
         state    <= RST_STATE;
         clr_cnt  <= '0;
         wait_cnt <= '0;
      end else begin
         state    <= state_next;
         clr_cnt  <= clr_cnt_next;
         wait_cnt <= wait_cnt_next;
      end
   end

   always_comb begin : next_state
      state_next    = state;
      clr_cnt_next  = clr_cnt;
      wait_cnt_next = wait_cnt;
      unique case (state)
         CLEAR: begin
            clr_cnt_next = clr_cnt + 1'b1;
            if (clr_cnt == AW'(DEPTH - 1)) state_next = IDLE;
         end
         IDLE: begin
            if (accept) begin
               if (LATENCY > 0) begin
                  state_next    = WAIT;
                  wait_cnt_next = CW'(LATENCY);
               end else begin
                  state_next = RESP;
               end
            end
         end
         WAIT: begin
            wait_cnt_next = wait_cnt - 1'b1;
            if (wait_cnt == CW'(1)) state_next = RESP;
         end
         RESP:    state_next = IDLE;
         default: state_next = RST_STATE;
      endcase
   end

   // Array port arbitration (clear sweep vs. request) and next values of the output registers.
   always_comb begin : outputs
      we_c             = 1'b0;
      waddr_c          = idx[AW-1:0];
      wdata_c          = merged_c;
      ready_next       = (state_next == IDLE);
      busy_next        = (state_next == CLEAR);
      resp_valid_next  = (state_next == RESP);
      rdata_next       = rdata;
      err_next         = err;
      trace_valid_next = 1'b0;
      trace_next       = trace_q;
      unique case (state)
         CLEAR: begin
            we_c    = 1'b1;
            waddr_c = clr_cnt;
            wdata_c = '0;
         end
         IDLE: begin
            if (accept) begin
               err_next = !in_range;
               if (!in_range) begin
                  rdata_next = '0;
               end else if (is_write) begin
                  we_c             = 1'b1;
                  rdata_next       = merged_c;
                  trace_valid_next = 1'b1;
                  trace_next.addr  = {addr[WORD_W-1:2], 2'b00};
                  trace_next.wdata = merged_c;
               end else begin
                  rdata_next = mem_rdata_c;
               end
            end
         end
         RESP:    err_next = 1'b0;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin : out_reg
      if (!reset) begin
         ready       <= 1'b0;
         busy        <= CLEAR_ON_RESET;
         resp_valid  <= 1'b0;
         rdata       <= '0;
         err         <= 1'b0;
         trace_valid <= 1'b0;
         trace_q     <= '0;
      end else begin
         ready       <= ready_next;
         busy        <= busy_next;
         resp_valid  <= resp_valid_next;
         rdata       <= rdata_next;
         err         <= err_next;
         trace_valid <= trace_valid_next;
         trace_q     <= trace_next;
      end
   end

   assign trace_addr  = trace_q.addr;
   assign trace_wdata = trace_q.wdata;

endmodule

// File: doc/dm_banked_mem.md
Name: dm_banked_mem

Overview:
- Synthesizable, parametrised data memory for the CPU data bus, with byte-enable writes.
- Adds four things to a plain behavioural memory: a request/response handshake, configurable read latency, out-of-range error reporting, and a hardware clear sweep after reset.
- Emits a registered write-trace port so the bench can log stores.
- Sits between the CPU/bridge data port and the bench.

Parameters:
- DEPTH, 4096: number of 32-bit words; power of two, minimum 2.
- BASE_ADDR, 32'h0000_0000: byte address of word 0.
- LATENCY, 0: extra wait cycles before a response; range 0..7.
- CLEAR_ON_RESET, 1: when 1, zero the array after reset; when 0, array contents are undefined.

Ports:
- clk  in  1  sole clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low.
- req  in  1  request valid.
- byteen  in  4  byte write enables; 4'b0000 means read.
- addr  in  32  byte address; bits [1:0] are ignored (word-aligned).
- wdata  in  32  write data, byte lanes aligned to the word.
- ready  out  1  block can accept a request this cycle.
- busy  out  1  clear sweep in progress.
- resp_valid  out  1  one-cycle response pulse.
- rdata  out  32  read word, or the merged word after a write.
- err  out  1  qualifies resp_valid: address out of range.
- trace_valid  out  1  one-cycle pulse when a write commits.
- trace_addr  out  32  aligned byte address of the committed word.
- trace_wdata  out  32  full merged word written.

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low.
- Reset (reset=0) drives, immediately and asynchronously:
  - state to CLEAR if CLEAR_ON_RESET, otherwise IDLE;
  - clear counter to 0;
  - ready=0, resp_valid=0, rdata=0, err=0, trace_valid=0, trace_addr=0, trace_wdata=0;
  - busy=CLEAR_ON_RESET.
- States: CLEAR, IDLE, WAIT, RESP.
- CLEAR:
  - each cycle writes 0 to mem[cnt], then cnt++;
  - at cnt==DEPTH-1 the last word is written and the next state is IDLE;
  - ready=0 and busy=1 throughout; duration is exactly DEPTH cycles.
  - Reset asserted mid-sweep restarts the sweep from 0.
- IDLE: ready=1. A request is accepted on a rising edge with req=1 and ready=1.
- Index: idx = (addr - BASE_ADDR) >> 2 (32-bit wrap-around subtraction). In range iff idx < DEPTH.
- Accept, write (byteen != 0) and in range:
  - at the accept edge, merge bytes: lane i takes wdata lane i where byteen[i]=1, otherwise keeps the old mem byte; store the merged word to mem[idx];
  - latch rdata = merged word;
  - next cycle: trace_valid=1, trace_addr = {addr[31:2],2'b00}, trace_wdata = merged word.
- Accept, read (byteen == 0) and in range: latch rdata = mem[idx] at the accept edge.
- Accept, out of range: no array access, no trace; latch rdata=0 and err=1.
- After accept: next state is WAIT with counter=LATENCY if LATENCY>0, otherwise RESP.
- WAIT: ready=0; decrement the counter; at 1, go to RESP.
- RESP:
  - resp_valid=1 for exactly one cycle; rdata and err are valid in that cycle;
  - ready=0;
  - next state IDLE; err clears on leaving RESP.
- Timing:
  - resp_valid rises LATENCY+1 cycles after the accept edge;
  - at most one request outstanding;
  - maximum throughput is one request per LATENCY+2 cycles.
- Inputs are ignored while ready=0; the requester must hold or re-present them.
- Read-after-write to the same word in consecutive requests returns the merged value, because the write commits at its accept edge.
- trace_valid is never asserted during CLEAR; the sweep is untraced.
- trace_valid and resp_valid may be high in the same cycle when LATENCY=0.

Decomposition:
- Package dm_pkg:
  - state enum {CLEAR, IDLE, WAIT, RESP};
  - BYTE_LANES=4, WORD_W=32;
  - function merge_bytes(old, wdata, byteen).
- Sub-module dm_word_array: DEPTH x 32 storage with one synchronous write port and one asynchronous read port. The FSM arbitrates between the clear sweep and request writes.

Test Plan (DEPTH=16, BASE_ADDR=0 unless noted):
1. Reset, then release -> busy=1 and ready=0 for exactly 16 cycles, then ready=1. A read of every word returns 0 with err=0.
2. Write 0x12345678 to 0x8 with byteen=1111, then write 0xAABBCCDD to 0x8 with byteen=0101 (LATENCY=0):
   - second trace_wdata = 0x12BB56DD, trace_addr=0x8;
   - a read of 0xB returns 0x12BB56DD.
3. LATENCY=3: read accepted at edge k -> resp_valid high only in the cycle after edge k+3; ready=0 over edges k+1..k+4; ready=1 again after RESP.
4. Write to 0x40 (idx=16) with byteen=1111 -> resp_valid=1, err=1, rdata=0, no trace_valid. A following read of 0x0 returns 0 with err=0.
5. Assert reset low for one cycle during a clear sweep (cnt=7) -> busy stays 1 and the sweep restarts, giving 16 further cycles of busy. Outputs go to reset values immediately, without waiting for clk.
6. BASE_ADDR=0x0000_3000: a write to 0x3004 gives trace_addr=0x3004. A request to 0x2FFC wraps to a huge idx -> err=1.
